// File: rtl/uart_program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_program_loader: waits for the device start byte, then streams a     |
// | size byte and PROG_SIZE bytes from program memory over uart_tx.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_program_loader #(
  parameter logic [7:0]  START_BYTE     = 8'd100,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] PROG_SIZE,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_EN,
  input  logic [7:0] MEM_DATA,
  input  logic       RX_DONE,
  input  logic [7:0] RX_DATA,
  output logic       TX_SEND,
  output logic [7:0] TX_DATA,
  input  logic       TX_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [7:0] BYTE_COUNT
);

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_WAIT_START    = 4'd1,
    S_SIZE_SEND     = 4'd2,
    S_SIZE_RDY_LOW  = 4'd3,
    S_SIZE_WAIT_RDY = 4'd4,
    S_MEM_READ      = 4'd5,
    S_MEM_LATCH     = 4'd6,
    S_DATA_SEND     = 4'd7,
    S_DATA_RDY_LOW  = 4'd8,
    S_DATA_WAIT_RDY = 4'd9,
    S_NEXT          = 4'd10,
    S_DONE          = 4'd11,
    S_ERROR         = 4'd12
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  size_q, size_d;
  logic [7:0]  count_q, count_d;
  logic [23:0] timer_q, timer_d;
  logic        tx_send_q, tx_send_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        mem_en_q, mem_en_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    count_d    = count_q;
    timer_d    = timer_q;
    tx_send_d  = 1'b0;
    tx_data_d  = tx_data_q;
    mem_addr_d = mem_addr_q;
    busy_d     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    done_d     = (state_q == S_DONE);
    error_d    = (state_q == S_ERROR);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (START) begin
          if (PROG_SIZE == 8'd0) begin
            state_d = S_ERROR;
          end else begin
            size_d  = PROG_SIZE;
            count_d = 8'd0;
            timer_d = 24'd0;
            state_d = S_WAIT_START;
          end
        end
      end
      S_WAIT_START: begin
        // The start byte takes priority over a coincident timeout.
        if (RX_DONE && RX_DATA == START_BYTE) begin
          state_d = S_SIZE_SEND;
        end else if (timer_q == TIMEOUT_CYCLES - 24'd1) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      S_SIZE_SEND: begin
        tx_data_d = size_q;
        tx_send_d = 1'b1;
        state_d   = S_SIZE_RDY_LOW;
      end
      S_SIZE_RDY_LOW:  state_d = S_SIZE_WAIT_RDY;
      S_SIZE_WAIT_RDY: if (TX_READY) state_d = S_MEM_READ;
      S_MEM_READ:      state_d = S_MEM_LATCH;
      S_MEM_LATCH: begin
        tx_data_d = MEM_DATA;
        state_d   = S_DATA_SEND;
      end
      S_DATA_SEND: begin
        tx_send_d = 1'b1;
        state_d   = S_DATA_RDY_LOW;
      end
      S_DATA_RDY_LOW:  state_d = S_DATA_WAIT_RDY;
      S_DATA_WAIT_RDY: if (TX_READY) state_d = S_NEXT;
      S_NEXT: begin
        count_d = count_q + 8'd1;
        if ({1'b0, count_q} + 9'd1 == {1'b0, size_q}) state_d = S_DONE;
        else state_d = S_MEM_READ;
      end
      default: state_d = S_IDLE;
    endcase

    // Read is issued on entry to MEM_READ so the synchronous memory's data
    // is valid by the time MEM_LATCH captures it.
    mem_en_d = (state_d == S_MEM_READ) || (state_d == S_MEM_LATCH);
    if (state_d == S_MEM_READ) mem_addr_d = count_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      size_q     <= 8'd0;
      count_q    <= 8'd0;
      timer_q    <= 24'd0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'd0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign MEM_ADDR   = mem_addr_q;
  assign MEM_EN     = mem_en_q;
  assign TX_SEND    = tx_send_q;
  assign TX_DATA    = tx_data_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERROR      = error_q;
  assign BYTE_COUNT = count_q;

endmodule
`default_nettype wire

// File: doc/uart_program_loader.md
# uart_program_loader

Host-side counterpart of the board's UART program-mode handshake. It waits for the device's start byte, then sends a size byte and PROG_SIZE instruction bytes read from a local synchronous ROM/RAM. It sits between a byte source memory and the shared `uart_tx`/`uart_rx` modules. It is used on a second FPGA acting as the programming host and in system-level benches that drive the processor board end to end.

## Interface
Parameters:
- START_BYTE, 8'd100: byte the device sends to request a program.
- TIMEOUT_CYCLES, 24'd10_000_000: maximum number of cycles to wait for START_BYTE.

Ports:
- CLK, in, 1: the single clock.
- RESET, in, 1: synchronous, active-high reset.
- START, in, 1: one-cycle request to begin a transfer. Ignored unless the block is in IDLE, DONE or ERROR.
- PROG_SIZE, in, 8: number of instruction bytes to send. Sampled when START is accepted.
- MEM_ADDR, out, 8: read address into the program memory.
- MEM_EN, out, 1: program memory read enable.
- MEM_DATA, in, 8: program memory read data. Valid one cycle after MEM_EN is sampled high.
- RX_DONE, in, 1: one-cycle valid strobe from `uart_rx`.
- RX_DATA, in, 8: received byte from `uart_rx`.
- TX_SEND, out, 1: one-cycle send strobe to `uart_tx`.
- TX_DATA, out, 8: byte to `uart_tx`. Held stable from the TX_SEND cycle until TX_READY returns high.
- TX_READY, in, 1: `uart_tx` idle flag.
- BUSY, out, 1: high in every state except IDLE, DONE and ERROR.
- DONE, out, 1: level output, high in DONE.
- ERROR, out, 1: level output, high in ERROR.
- BYTE_COUNT, out, 8: number of instruction bytes fully sent so far.

## Operation
- States: IDLE, WAIT_START, SIZE_SEND, SIZE_RDY_LOW, SIZE_WAIT_RDY, MEM_READ, MEM_LATCH, DATA_SEND, DATA_RDY_LOW, DATA_WAIT_RDY, NEXT, DONE, ERROR.
- IDLE / DONE / ERROR, on START:
  - If PROG_SIZE == 0: go to ERROR.
  - Otherwise: latch PROG_SIZE, clear BYTE_COUNT and the timeout counter, go to WAIT_START.
- WAIT_START:
  - RX_DONE with RX_DATA == START_BYTE: go to SIZE_SEND.
  - RX_DONE with any other byte: discard it and stay. The timeout counter keeps running.
  - Counter reaches TIMEOUT_CYCLES-1: go to ERROR.
- SIZE_SEND: TX_DATA <= latched size, TX_SEND <= 1, go to SIZE_RDY_LOW.
- SIZE_RDY_LOW: TX_SEND <= 0. This is a one-cycle guard so the stale READY from before the send is not sampled. Go to SIZE_WAIT_RDY.
- SIZE_WAIT_RDY: when TX_READY == 1, go to MEM_READ.
- MEM_READ: MEM_EN <= 1, MEM_ADDR <= BYTE_COUNT, go to MEM_LATCH.
- MEM_LATCH: TX_DATA <= MEM_DATA, MEM_EN <= 0, go to DATA_SEND.
- DATA_SEND, DATA_RDY_LOW and DATA_WAIT_RDY behave exactly like the three SIZE_ states; DATA_WAIT_RDY exits to NEXT.
- NEXT:
  - BYTE_COUNT <= BYTE_COUNT + 1 (8-bit).
  - If BYTE_COUNT + 1 == latched size (compare in 9 bits, no wrap): go to DONE. Otherwise go to MEM_READ.
- RX bytes arriving after WAIT_START are ignored.
- START while BUSY is ignored. PROG_SIZE changes while BUSY have no effect.

## Timing
- Reset values, applied on the first CLK edge with RESET high:
  - State IDLE.
  - TX_SEND=0, TX_DATA=0, MEM_EN=0, MEM_ADDR=0.
  - BUSY=0, DONE=0, ERROR=0, BYTE_COUNT=0.
- RESET has priority over every other input. Reset mid-transfer aborts the transfer within one cycle, drops TX_SEND and stops further sends. A byte already inside `uart_tx` still completes on the line.
- START accepted at edge n: BUSY is high from n+1.
- Start byte detected at edge m (RX_DONE high): TX_SEND is high during cycle m+1.
- Per data byte, excluding UART time: MEM_READ, MEM_LATCH, DATA_SEND, DATA_RDY_LOW, ≥1 cycle of DATA_WAIT_RDY, NEXT = minimum 6 cycles.
- Exactly one TX_SEND pulse per transmitted byte, each one cycle wide. Never two pulses without a TX_READY==1 observation between them.
- DONE and ERROR are asserted the cycle after the final transition and hold until START or RESET.
- RX_DONE coincident with the timeout terminal count: the start byte wins (go to SIZE_SEND).

## Test plan
- Nominal transfer: PROG_SIZE=3, ROM {0xA1,0xB2,0xC3}, RX delivers 0x64. Required: TX byte sequence 0x03,0xA1,0xB2,0xC3; DONE=1; BYTE_COUNT=3; exactly 4 TX_SEND pulses.
- Noise before start byte: RX delivers 0x00, 0x65, then 0x64. Required: no TX_SEND before the 0x64; output sequence identical to the nominal case.
- Timeout: TIMEOUT_CYCLES=100, no RX bytes. Required: ERROR rises at cycle 101 after START; zero TX_SEND pulses. A following START with PROG_SIZE=1 recovers and completes normally.
- Boundaries:
  - PROG_SIZE=0: ERROR asserted the next cycle with no TX activity.
  - PROG_SIZE=255: 256 bytes sent, MEM_ADDR reaches 254, BYTE_COUNT=255, DONE=1.
- Slow transmitter: uart_tx model holds READY low for 1000 cycles per byte. Required: TX_DATA stable throughout each byte; no extra pulses; START while BUSY is ignored.
- Reset mid-transfer: assert RESET during DATA_WAIT_RDY of byte 2. Required: next cycle state is IDLE, all outputs at reset values, no further TX_SEND pulses.
